// File: rtl/sd_cmd.sv
// SD CMD-line engine: shifts out a 48-bit command with on-the-fly CRC7, then captures and checks the card response.
// Response checking (CRC7, index, transmission and end bits) is built only when SD_CMD_RESP_CHECK_EN is defined.
module sd_cmd #(
    parameter int NCR_MAX = 64,
    parameter int NCC     = 8
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istb,
    input  logic        istart,
    input  logic [5:0]  icmd_index,
    input  logic [31:0] icmd_arg,
    input  logic        icmd_sd,
    output logic        ocmd_sd,
    output logic        ocmd_oe,
    output logic [31:0] oresp,
    output logic        odone,
    output logic        ocrc_fail,
    output logic        otimeout,
    output logic        obusy
);
    localparam int            TW       = $clog2(NCR_MAX + 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(NCR_MAX);
    localparam logic [TW-1:0] TMO_LAST = TW'(NCR_MAX - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [7:0]    GAP_LAST = 8'(NCC - 1);
`ifdef SD_CMD_RESP_CHECK_EN
    localparam int RX_W = 134;
`else
    localparam int RX_W = 127;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT_RESP, ST_RECV, ST_GAP, ST_DONE
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [5:0]      idx_r;
    logic [39:0]     tx_sr_r;
    logic [6:0]      crc_r;
    logic [7:0]      bit_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [RX_W-1:0] rx_sr_r;
    logic            sd_r, oe_r, done_r, tmo_r, busy_r;
    logic [31:0]     resp_r;
    logic            resp_none_s, resp_long_s;
    logic [7:0]      rx_last_s;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign resp_none_s = (idx_r == 6'd15);
    assign resp_long_s = (idx_r == 6'd2);
    // rx_last_s is the bit-counter value at the final response bit (start bit is count 0)
    assign rx_last_s   = resp_long_s ? 8'd135 : 8'd47;

    // State register
    always_ff @(posedge iclk) begin
        if (irst) state_r <= ST_IDLE;
        else      state_r <= state_nxt_s;
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (istart) state_nxt_s = ST_SEND;
                else        state_nxt_s = ST_IDLE;
            end
            ST_SEND: begin
                if (istb && bit_cnt_r == 8'd48) state_nxt_s = resp_none_s ? ST_GAP : ST_WAIT_RESP;
                else                            state_nxt_s = ST_SEND;
            end
            ST_WAIT_RESP: begin
                if (istb && !icmd_sd)                     state_nxt_s = ST_RECV;
                else if (istb && tmo_cnt_r == TMO_LAST)   state_nxt_s = ST_GAP;
                else                                      state_nxt_s = ST_WAIT_RESP;
            end
            ST_RECV: begin
                if (istb && bit_cnt_r == rx_last_s) state_nxt_s = ST_GAP;
                else                                state_nxt_s = ST_RECV;
            end
            ST_GAP: begin
                if (istb && bit_cnt_r == GAP_LAST) state_nxt_s = ST_DONE;
                else                               state_nxt_s = ST_GAP;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

`ifdef SD_CMD_RESP_CHECK_EN
    logic resp_r3_s, crc_en_s, chk_fail_s, crc_fail_r;
    assign resp_r3_s = (idx_r == 6'd41);
    // R2 CRC covers bits 127..1 (counts 8..134); 48-bit responses cover bits 47..1
    assign crc_en_s  = (bit_cnt_r < rx_last_s) && (!resp_long_s || bit_cnt_r >= 8'd8);

    // Verdict on the final response bit; rx_sr_r holds bits [N-1:1] so bit k sits at rx_sr_r[k-1]
    always_comb begin
        chk_fail_s = 1'b0;
        if (resp_long_s) begin
            chk_fail_s = rx_sr_r[133] | (rx_sr_r[132:127] != 6'h3F) | (crc_r != 7'd0) | ~icmd_sd;
        end else if (resp_r3_s) begin
            chk_fail_s = rx_sr_r[45] | (rx_sr_r[44:39] != 6'h3F) | ~icmd_sd;
        end else begin
            chk_fail_s = rx_sr_r[45] | (rx_sr_r[44:39] != idx_r) | (crc_r != 7'd0) | ~icmd_sd;
        end
    end

    // Check flag: cleared on an accepted start, captured when the last response bit arrives
    always_ff @(posedge iclk) begin
        if (irst)                                                  crc_fail_r <= 1'b0;
        else if (state_r == ST_IDLE && istart)                     crc_fail_r <= 1'b0;
        else if (state_r == ST_RECV && istb && bit_cnt_r == rx_last_s) crc_fail_r <= chk_fail_s;
        else                                                       crc_fail_r <= crc_fail_r;
    end
    assign ocrc_fail = crc_fail_r;
`else
    assign ocrc_fail = 1'b0;
`endif

    // Datapath: shifting, counters and registered pad/status outputs
    always_ff @(posedge iclk) begin
        if (irst) begin
            idx_r     <= 6'd0;
            tx_sr_r   <= 40'd0;
            crc_r     <= 7'd0;
            bit_cnt_r <= 8'd0;
            tmo_cnt_r <= {TW{1'b0}};
            rx_sr_r   <= {RX_W{1'b0}};
            sd_r      <= 1'b1;
            oe_r      <= 1'b0;
            resp_r    <= 32'd0;
            done_r    <= 1'b0;
            tmo_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= (state_nxt_s == ST_DONE);
            busy_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (istart) begin
                        idx_r     <= icmd_index;
                        tx_sr_r   <= {2'b01, icmd_index, icmd_arg};
                        crc_r     <= 7'd0;
                        bit_cnt_r <= 8'd0;
                        tmo_r     <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (istb) begin
                        if (bit_cnt_r < 8'd40) begin
                            sd_r    <= tx_sr_r[39];
                            crc_r   <= crc7_step(crc_r, tx_sr_r[39]);
                            tx_sr_r <= {tx_sr_r[38:0], 1'b0};
                        end else if (bit_cnt_r < 8'd47) begin
                            sd_r  <= crc_r[6];
                            crc_r <= {crc_r[5:0], 1'b0};
                        end else begin
                            sd_r <= 1'b1;
                        end
                        if (bit_cnt_r == 8'd48) begin
                            oe_r      <= 1'b0;
                            bit_cnt_r <= 8'd0;
                            tmo_cnt_r <= {TW{1'b0}};
                        end else begin
                            oe_r      <= 1'b1;
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (istb) begin
                        if (!icmd_sd) begin
                            bit_cnt_r <= 8'd1;
                            crc_r     <= 7'd0;
                        end else begin
                            if (tmo_cnt_r != TMO_LIM) tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                            if (tmo_cnt_r == TMO_LAST) begin
                                tmo_r     <= 1'b1;
                                bit_cnt_r <= 8'd0;
                            end
                        end
                    end
                end
                ST_RECV: begin
                    if (istb) begin
                        rx_sr_r <= {rx_sr_r[RX_W-2:0], icmd_sd};
`ifdef SD_CMD_RESP_CHECK_EN
                        if (crc_en_s) crc_r <= crc7_step(crc_r, icmd_sd);
`endif
                        if (bit_cnt_r == rx_last_s) begin
                            resp_r    <= resp_long_s ? rx_sr_r[126:95] : rx_sr_r[38:7];
                            bit_cnt_r <= 8'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (istb) bit_cnt_r <= (bit_cnt_r == GAP_LAST) ? 8'd0 : bit_cnt_r + 8'd1;
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

    assign ocmd_sd  = sd_r;
    assign ocmd_oe  = oe_r;
    assign oresp    = resp_r;
    assign odone    = done_r;
    assign otimeout = tmo_r;
    assign obusy    = busy_r;
endmodule
